// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: per-pin synchroniser and edge detect, pending/enable
// registers, lowest-index priority and a claim/complete handshake to the core.

module gpio_irq_pin #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sff;
    logic                   prev;

    // prev follows sync unconditionally so a direction flip never sees a stale edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sff  <= '0;
            prev <= 1'b0;
        end else begin
            sff  <= {sff[SYNC_STAGES-2:0], pin};
            prev <= sff[SYNC_STAGES-1];
        end
    end

    assign rise = sff[SYNC_STAGES-1] & ~prev;
    assign fall = ~sff[SYNC_STAGES-1] & prev;
endmodule

module gpio_irq_ctrl #(
    parameter int NUM_PINS    = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PINS-1:0]         gpio_in_i,
    input  logic [NUM_PINS-1:0]         dir_i,
    input  logic                        cfg_we_i,
    input  logic [1:0]                  cfg_addr_i,
    input  logic [NUM_PINS-1:0]         cfg_wdata_i,
    output logic [NUM_PINS-1:0]         cfg_rdata_o,
    output logic                        irq_o,
    output logic [$clog2(NUM_PINS)-1:0] irq_id_o,
    input  logic                        claim_i,
    input  logic                        complete_i
);
    localparam int ID_W = $clog2(NUM_PINS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_PINS-1:0] reg_en, reg_rise, reg_fall, reg_pend;
    logic [NUM_PINS-1:0] rise_det, fall_det;
    logic [NUM_PINS-1:0] ev, masked, w1c, claim_clr, pend_d;
    logic [ID_W-1:0]     winner, id_d;
    logic                irq_d;

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
        gpio_irq_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .clk  (clk),
            .rst  (rst),
            .pin  (gpio_in_i[g]),
            .rise (rise_det[g]),
            .fall (fall_det[g])
        );
    end

    assign ev     = dir_i & ((rise_det & reg_rise) | (fall_det & reg_fall));
    assign masked = reg_pend & reg_en;
    assign w1c    = (cfg_we_i && cfg_addr_i == 2'd3) ? cfg_wdata_i : '0;

    // Scan downwards so the lowest set index is the last one written
    always_comb begin
        winner = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (masked[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_d     = irq_o;
        id_d      = irq_id_o;
        claim_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (|masked) begin
                    id_d    = winner;
                    irq_d   = 1'b1;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                // Software withdrawing the source takes priority over a claim
                if (!reg_pend[irq_id_o] || !reg_en[irq_id_o]) begin
                    irq_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (claim_i) begin
                    claim_clr[irq_id_o] = 1'b1;
                    irq_d               = 1'b0;
                    state_d             = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (complete_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // New events win over any clear landing on the same bit
    assign pend_d = (reg_pend & ~(w1c | claim_clr)) | ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            reg_en   <= '0;
            reg_rise <= '0;
            reg_fall <= '0;
            reg_pend <= '0;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            state_q  <= state_d;
            reg_pend <= pend_d;
            irq_o    <= irq_d;
            irq_id_o <= id_d;
            if (cfg_we_i) begin
                case (cfg_addr_i)
                    2'd0:    reg_en   <= cfg_wdata_i;
                    2'd1:    reg_rise <= cfg_wdata_i;
                    2'd2:    reg_fall <= cfg_wdata_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (cfg_addr_i)
            2'd0:    cfg_rdata_o = reg_en;
            2'd1:    cfg_rdata_o = reg_rise;
            2'd2:    cfg_rdata_o = reg_fall;
            default: cfg_rdata_o = reg_pend;
        endcase
    end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a sample-history reference model.
module tb_gpio_irq_ctrl;
    localparam int NP = 24;
    localparam int SS = 2;
    localparam int IW = $clog2(NP);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] gpio_in = '0;
    logic [NP-1:0] dir = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = 2'd3;
    logic [NP-1:0] cfg_wdata = '0;
    logic [NP-1:0] cfg_rdata;
    logic          irq;
    logic [IW-1:0] irq_id;
    logic          claim = 1'b0;
    logic          complete = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    gpio_irq_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_in_i   (gpio_in),
        .dir_i       (dir),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .irq_o       (irq),
        .irq_id_o    (irq_id),
        .claim_i     (claim),
        .complete_i  (complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin levels kept as a history of clock samples; sync is the
    // sample SS-1 edges old, the previous level the one SS edges old.
    logic [NP-1:0] m_en = '0, m_rise = '0, m_fall = '0, m_pend = '0;
    logic [NP-1:0] hist [0:SS];
    bit            m_irq = 1'b0, m_serv = 1'b0;
    int            m_id = 0;

    function automatic int lowest(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [NP-1:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_en;
            2'd1:    return m_rise;
            2'd2:    return m_fall;
            default: return m_pend;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [NP-1:0] ev, clr, live, cur, old;
        if (rst) begin
            m_en = '0; m_rise = '0; m_fall = '0; m_pend = '0;
            m_irq = 1'b0; m_serv = 1'b0; m_id = 0;
            for (int i = 0; i <= SS; i++) hist[i] = '0;
        end else begin
            cur  = hist[SS-1];
            old  = hist[SS];
            ev   = dir & ((cur & ~old & m_rise) | (~cur & old & m_fall));
            clr  = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : '0;
            live = m_pend & m_en;
            if (m_irq) begin
                if (!m_pend[m_id] || !m_en[m_id]) m_irq = 1'b0;
                else if (claim) begin
                    clr[m_id] = 1'b1;
                    m_irq = 1'b0;
                    m_serv = 1'b1;
                end
            end else if (m_serv) begin
                if (complete) m_serv = 1'b0;
            end else if (live != '0) begin
                m_id  = lowest(live);
                m_irq = 1'b1;
            end
            m_pend = (m_pend & ~clr) | ev;
            if (cfg_we) begin
                if (cfg_addr == 2'd0) m_en = cfg_wdata;
                if (cfg_addr == 2'd1) m_rise = cfg_wdata;
                if (cfg_addr == 2'd2) m_fall = cfg_wdata;
            end
            for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gpio_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model irq_o", irq, m_irq);
            chk("model irq_id_o", irq_id, m_id);
            chk("model cfg_rdata_o", cfg_rdata, m_rd(cfg_addr));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [NP-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_addr = 2'd3; cfg_wdata = '0;
    endtask

    task automatic pulse_claim();
        claim = 1'b1; tick(); claim = 1'b0;
    endtask

    task automatic pulse_complete();
        complete = 1'b1; tick(); complete = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] rem;
        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset irq_o", irq, 0);
        chk("reset irq_id_o", irq_id, 0);
        chk("reset pend", cfg_rdata, 0);

        // Single rising edge on pin 0
        dir = '1;
        wr(2'd0, 24'h000001);
        wr(2'd1, 24'h000001);
        gpio_in[0] = 1'b1;
        tick(2);
        chk("t1 pend k+1", cfg_rdata, 0);
        tick();
        chk("t1 pend k+2", cfg_rdata, 24'h000001);
        chk("t1 irq k+2", irq, 0);
        tick();
        chk("t1 irq k+3", irq, 1);
        chk("t1 id k+3", irq_id, 0);
        pulse_claim();
        chk("t1 irq after claim", irq, 0);
        chk("t1 pend after claim", cfg_rdata, 0);
        pulse_complete();
        tick(2);
        chk("t1 idle irq", irq, 0);

        // Port B falling edges serviced in index order
        wr(2'd1, 24'h0);
        wr(2'd2, 24'h00FF00);
        wr(2'd0, 24'h00FF00);
        dir = 24'h00FF00;
        gpio_in = 24'h00FF01;
        tick(4);
        chk("t2 pend quiet", cfg_rdata, 0);
        gpio_in = 24'h00AA01;
        tick(3);
        chk("t2 pend", cfg_rdata, 24'h005500);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2 irq", irq, 1);
            chk("t2 id", irq_id, 8 + 2 * i);
            pulse_claim();
            rem = 24'h005500 & ~((24'h1 << (9 + 2 * i)) - 24'h1);
            chk("t2 irq after claim", irq, 0);
            chk("t2 pend after claim", cfg_rdata, rem);
            pulse_complete();
            chk("t2 irq after complete", irq, 0);
            tick();
        end
        chk("t2 final irq", irq, 0);

        // Output pins never raise events
        wr(2'd2, 24'h0);
        wr(2'd1, 24'hFFFFFF);
        wr(2'd0, 24'hFFFFFF);
        dir = '0;
        for (int i = 0; i < 8; i++) begin
            gpio_in = ~gpio_in;
            tick();
        end
        tick(4);
        chk("t3 pend", cfg_rdata, 0);
        chk("t3 irq", irq, 0);

        // Retract by W1C of the signalled pin
        wr(2'd1, 24'h0);
        wr(2'd0, 24'h0);
        gpio_in = '0;
        tick(4);
        dir = '1;
        wr(2'd1, 24'h010000);
        wr(2'd0, 24'h010000);
        gpio_in[16] = 1'b1;
        tick(4);
        chk("t4 irq", irq, 1);
        chk("t4 id", irq_id, 16);
        wr(2'd3, 24'h010000);
        chk("t4 pend cleared", cfg_rdata, 0);
        tick();
        chk("t4 irq retracted", irq, 0);
        tick(3);
        chk("t4 stays idle", irq, 0);

        // Re-trigger during service, then same-cycle set/W1C
        wr(2'd0, 24'h0);
        wr(2'd1, 24'h000008);
        wr(2'd0, 24'h000008);
        gpio_in[3] = 1'b1;
        tick(4);
        chk("t5 id", irq_id, 3);
        pulse_claim();
        chk("t5 pend claimed", cfg_rdata, 0);
        gpio_in[3] = 1'b0;
        tick(3);
        gpio_in[3] = 1'b1;
        tick(3);
        chk("t5 retrigger pend", cfg_rdata, 24'h000008);
        chk("t5 irq in service", irq, 0);
        pulse_complete();
        chk("t5 irq at d", irq, 0);
        tick();
        chk("t5 irq at d+1", irq, 1);
        chk("t5 id at d+1", irq_id, 3);
        pulse_claim();
        pulse_complete();
        tick();
        gpio_in[3] = 1'b0;
        tick(3);
        gpio_in[3] = 1'b1;
        tick(2);
        wr(2'd3, 24'h000008);
        chk("t5 set wins over w1c", cfg_rdata, 24'h000008);
        tick();
        chk("t5 same-cycle irq", irq, 1);
        pulse_claim();
        pulse_complete();
        tick();

        // Reset mid-ASSERT
        wr(2'd1, 24'h0);
        wr(2'd0, 24'h0);
        gpio_in = '0;
        tick(3);
        wr(2'd1, 24'hCC0000);
        wr(2'd0, 24'hCC0000);
        gpio_in = 24'hCC0000;
        tick(4);
        chk("t6 pend", cfg_rdata, 24'hCC0000);
        chk("t6 id", irq_id, 18);
        rst = 1'b1;
        tick();
        chk("t6 irq", irq, 0);
        chk("t6 id reset", irq_id, 0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk("t6 reg reset", cfg_rdata, 0);
        end
        cfg_addr = 2'd3;
        rst = 1'b0;
        tick(2);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(1) == 0)
                gpio_in = gpio_in ^ (NP'(1) << $urandom_range(NP - 1));
            if ($urandom_range(15) == 0)
                gpio_in = NP'($urandom);
            if ($urandom_range(63) == 0)
                dir = NP'($urandom);
            cfg_we    = ($urandom_range(7) == 0);
            cfg_addr  = 2'($urandom_range(3));
            cfg_wdata = NP'($urandom);
            claim     = ($urandom_range(2) == 0);
            complete  = ($urandom_range(2) == 0);
            rst       = ($urandom_range(999) == 0);
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0; claim = 1'b0; complete = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
